hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage MIPS core.
- Drives the enable of the IF/ID register and the PC register, the ID/EX flush, and all forwarding selects.
- Tracks the multi-cycle multiply/divide unit (MDU) with an internal busy counter, so HI/LO reads and back-to-back MDU ops stall in ID.
- Branch delay slot architecture: no IF/ID flush on a taken branch or jump.

---
 rtl/hazard_ctrl_pkg.sv | 19 +
 rtl/hazard_ctrl_mdu_busy_cnt.sv | 45 ++++
 rtl/hazard_ctrl.sv | 111 +++++++++++
 tb/tb_hazard_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller.
package hazard_ctrl_pkg;

    // Forwarding select encodings for the EX operand muxes.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Default multiply/divide unit occupancy after the op leaves EX.
    localparam int unsigned MULT_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF  = 32;

    // MDU tracker state: BUSY exactly when the busy counter is non-zero.
    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_t;

endpackage

// File: rtl/hazard_ctrl_mdu_busy_cnt.sv
// Busy tracker for the multi-cycle multiply/divide unit.
// A start (re)loads the counter with the op latency; it then counts down to zero.
module mdu_busy_cnt
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
    parameter int unsigned CNT_W    = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    mdu_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    // State and counter registers; reset wins over a concurrent start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= MDU_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next counter value: restart on start, else decrement while busy (never underflows).
    always_comb begin
        cnt_nxt   = cnt;
        state_nxt = state;
        if (start) begin
            cnt_nxt = is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (state == MDU_BUSY) begin
            cnt_nxt = cnt - CNT_W'(1);
        end
        state_nxt = (cnt_nxt != '0) ? MDU_BUSY : MDU_IDLE;
    end

    assign busy = (state == MDU_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core:
// load-use / branch / MDU stalls and all forwarding selects.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
    parameter int unsigned CNT_W    = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic       useRsD,
    input  logic       useRtD,
    input  logic       branchD,
    input  logic       mduOpD,
    input  logic       mduReadD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeregE,
    input  logic [4:0] writeregM,
    input  logic [4:0] writeregW,
    input  logic       regwriteE,
    input  logic       regwriteM,
    input  logic       regwriteW,
    input  logic       memtoregE,
    input  logic       memtoregM,
    input  logic       mduStartE,
    input  logic       mduDivE,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       flushE,
    output logic       forwardAD,
    output logic       forwardBD,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic       mdu_busy
);

    logic busy;

    mdu_busy_cnt #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) u_mdu_busy_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mduStartE),
        .is_div (mduDivE),
        .busy   (busy)
    );

    logic rs_hit_e, rt_hit_e, rs_hit_m, rt_hit_m;
    logic lwstall, brstall, mdustall, stall;
    logic fwd_ad, fwd_bd;
    logic [1:0] fwd_ae, fwd_be;

    // Hazard detection and forwarding; $0 is never a valid destination.
    always_comb begin
        rs_hit_e = useRsD && (writeregE != '0) && (rsD == writeregE);
        rt_hit_e = useRtD && (writeregE != '0) && (rtD == writeregE);
        rs_hit_m = useRsD && (writeregM != '0) && (rsD == writeregM);
        rt_hit_m = useRtD && (writeregM != '0) && (rtD == writeregM);

        lwstall  = memtoregE && regwriteE && (rs_hit_e || rt_hit_e);
        brstall  = branchD && ((regwriteE && (rs_hit_e || rt_hit_e)) ||
                               (memtoregM && (rs_hit_m || rt_hit_m)));
        mdustall = (mduReadD || mduOpD) && (busy || mduStartE);
        stall    = lwstall || brstall || mdustall;

        fwd_ad = regwriteM && (writeregM != '0) && (writeregM == rsD);
        fwd_bd = regwriteM && (writeregM != '0) && (writeregM == rtD);

        fwd_ae = FWD_RF;
        if (regwriteM && (writeregM != '0) && (writeregM == rsE))
            fwd_ae = FWD_MEM;
        else if (regwriteW && (writeregW != '0) && (writeregW == rsE))
            fwd_ae = FWD_WB;

        fwd_be = FWD_RF;
        if (regwriteM && (writeregM != '0) && (writeregM == rtE))
            fwd_be = FWD_MEM;
        else if (regwriteW && (writeregW != '0) && (writeregW == rtE))
            fwd_be = FWD_WB;
    end

    // Output stage: while in reset the pipeline runs free and flushes EX.
    always_comb begin
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        flushE    = 1'b1;
        forwardAD = 1'b0;
        forwardBD = 1'b0;
        forwardAE = FWD_RF;
        forwardBE = FWD_RF;
        mdu_busy  = 1'b0;
        if (rst_n) begin
            pc_en     = !stall;
            if_id_en  = !stall;
            flushE    = stall;
            forwardAD = fwd_ad;
            forwardBD = fwd_bd;
            forwardAE = fwd_ae;
            forwardBE = fwd_be;
            mdu_busy  = busy;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       useRsD, useRtD, branchD, mduOpD, mduReadD;
    logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic       mduStartE, mduDivE;
    logic       pc_en, if_id_en, flushE, forwardAD, forwardBD, mdu_busy;
    logic [1:0] forwardAE, forwardBE;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .MULT_LAT (5),
        .DIV_LAT  (32),
        .CNT_W    (6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rsD       (rsD),
        .rtD       (rtD),
        .useRsD    (useRsD),
        .useRtD    (useRtD),
        .branchD   (branchD),
        .mduOpD    (mduOpD),
        .mduReadD  (mduReadD),
        .rsE       (rsE),
        .rtE       (rtE),
        .writeregE (writeregE),
        .writeregM (writeregM),
        .writeregW (writeregW),
        .regwriteE (regwriteE),
        .regwriteM (regwriteM),
        .regwriteW (regwriteW),
        .memtoregE (memtoregE),
        .memtoregM (memtoregM),
        .mduStartE (mduStartE),
        .mduDivE   (mduDivE),
        .pc_en     (pc_en),
        .if_id_en  (if_id_en),
        .flushE    (flushE),
        .forwardAD (forwardAD),
        .forwardBD (forwardBD),
        .forwardAE (forwardAE),
        .forwardBE (forwardBE),
        .mdu_busy  (mdu_busy)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clr_inputs();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0;
        writeregE = 0; writeregM = 0; writeregW = 0;
        useRsD = 0; useRtD = 0; branchD = 0; mduOpD = 0; mduReadD = 0;
        regwriteE = 0; regwriteM = 0; regwriteW = 0;
        memtoregE = 0; memtoregM = 0; mduStartE = 0; mduDivE = 0;
    endtask

    // Advance to the next cycle; inputs are driven 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stall signature: pc_en, if_id_en, flushE packed as 3 bits.
    function automatic logic [7:0] stall_vec();
        return {5'b0, pc_en, if_id_en, flushE};
    endfunction

    localparam logic [7:0] RUN   = 8'b110;
    localparam logic [7:0] STALL = 8'b001;
    localparam logic [7:0] RSTV  = 8'b111;

    initial begin
        rst_n = 1'b0;
        clr_inputs();
        // Hazards presented during reset must be masked.
        memtoregE = 1; regwriteE = 1; writeregE = 8; rsD = 8; useRsD = 1;
        regwriteM = 1; writeregM = 8; rsE = 8; mduReadD = 1; mduStartE = 1;
        #1;
        check("rst_stall", stall_vec(), RSTV);
        check("rst_fwdAE", forwardAE, 8'd0);
        check("rst_fwdAD", forwardAD, 1'b0);
        check("rst_busy",  mdu_busy, 1'b0);
        tick();
        check("rst_busy_after_edge", mdu_busy, 1'b0);
        rst_n = 1'b1;
        clr_inputs();
        tick();
        check("idle_stall", stall_vec(), RUN);
        check("idle_busy",  mdu_busy, 1'b0);

        // Load-use: lw $8 in EX, add reads $8 in ID.
        memtoregE = 1; regwriteE = 1; writeregE = 8; rsD = 8; useRsD = 1;
        #1 check("lw_use_stall", stall_vec(), STALL);
        tick();
        clr_inputs();
        memtoregM = 1; regwriteM = 1; writeregM = 8; rsD = 8; useRsD = 1;
        #1 check("lw_use_release", stall_vec(), RUN);
        tick();
        clr_inputs();
        regwriteW = 1; writeregW = 8; rsE = 8;
        #1 check("lw_use_fwdAE_wb", forwardAE, 8'b01);
        // Same load, ID does not actually read rs.
        clr_inputs();
        memtoregE = 1; regwriteE = 1; writeregE = 8; rsD = 8; useRsD = 0;
        #1 check("lw_nouse_nostall", stall_vec(), RUN);
        // Load-use through rt.
        clr_inputs();
        memtoregE = 1; regwriteE = 1; writeregE = 12; rtD = 12; useRtD = 1;
        #1 check("lw_use_rt_stall", stall_vec(), STALL);

        // Branch operand produced by ALU op in EX.
        tick();
        clr_inputs();
        branchD = 1; rsD = 9; useRsD = 1; regwriteE = 1; writeregE = 9;
        #1 check("br_ex_stall", stall_vec(), STALL);
        tick();
        clr_inputs();
        branchD = 1; rsD = 9; useRsD = 1; regwriteM = 1; writeregM = 9;
        #1 check("br_mem_alu_nostall", stall_vec(), RUN);
        check("br_fwdAD", forwardAD, 1'b1);
        check("br_fwdBD_off", forwardBD, 1'b0);
        // Branch operand from a load still in MEM.
        clr_inputs();
        branchD = 1; rtD = 10; useRtD = 1; memtoregM = 1; regwriteM = 1; writeregM = 10;
        #1 check("br_mem_load_stall", stall_vec(), STALL);
        check("br_fwdBD", forwardBD, 1'b1);
        // Non-branch with same ALU dependency does not stall in ID.
        clr_inputs();
        rsD = 9; useRsD = 1; regwriteE = 1; writeregE = 9;
        #1 check("nobr_alu_nostall", stall_vec(), RUN);

        // Register $0 never matches.
        clr_inputs();
        regwriteM = 1; writeregM = 0; rsE = 0; rsD = 0;
        regwriteW = 1; writeregW = 0; rtE = 0;
        #1 check("zero_fwdAE", forwardAE, 8'b00);
        check("zero_fwdBE", forwardBE, 8'b00);
        check("zero_fwdAD", forwardAD, 1'b0);
        clr_inputs();
        memtoregE = 1; regwriteE = 1; writeregE = 0; rsD = 0; useRsD = 1; branchD = 1;
        #1 check("zero_lw_nostall", stall_vec(), RUN);

        // MEM over WB priority.
        clr_inputs();
        regwriteM = 1; writeregM = 5; regwriteW = 1; writeregW = 5; rsE = 5; rtE = 5;
        #1 check("prio_fwdAE_mem", forwardAE, 8'b10);
        check("prio_fwdBE_mem", forwardBE, 8'b10);
        writeregM = 6; rtE = 6;
        #1 check("fwdAE_wb_only", forwardAE, 8'b01);
        check("fwdBE_mem_only", forwardBE, 8'b10);
        regwriteM = 0;
        #1 check("fwdBE_rm_off", forwardBE, 8'b00);

        // Multiply, mfhi in ID from the launch cycle: stall T..T+5, free at T+6.
        clr_inputs();
        mduStartE = 1; mduDivE = 0; mduReadD = 1;
        #1 check("mul_T_stall", stall_vec(), STALL);
        check("mul_T_busy_not_comb", mdu_busy, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            mduStartE = 0;
            #1 check($sformatf("mul_T+%0d_stall", k), stall_vec(), STALL);
            check($sformatf("mul_T+%0d_busy", k), mdu_busy, 1'b1);
        end
        tick();
        #1 check("mul_T+6_release", stall_vec(), RUN);
        check("mul_T+6_busy", mdu_busy, 1'b0);

        // Divide, mult/div op in ID: stall T..T+32, free at T+33.
        mduStartE = 1; mduDivE = 1; mduReadD = 0; mduOpD = 1;
        #1 check("div_T_stall", stall_vec(), STALL);
        for (int k = 1; k <= 32; k++) begin
            tick();
            mduStartE = 0; mduDivE = 0;
            #1 check($sformatf("div_T+%0d_stall", k), stall_vec(), STALL);
        end
        tick();
        #1 check("div_T+33_release", stall_vec(), RUN);
        check("div_T+33_busy", mdu_busy, 1'b0);

        // Restart: mult at T, div at T+2 reloads -> busy through T+34.
        clr_inputs();
        mduStartE = 1;
        tick();
        mduStartE = 0;
        tick();
        mduStartE = 1; mduDivE = 1;
        for (int k = 3; k <= 34; k++) begin
            tick();
            mduStartE = 0; mduDivE = 0;
        end
        #1 check("restart_T+34_busy", mdu_busy, 1'b1);
        tick();
        check("restart_T+35_idle", mdu_busy, 1'b0);

        // MDU launch coinciding with a load-use stall still loads the counter.
        clr_inputs();
        memtoregE = 1; regwriteE = 1; writeregE = 7; rsD = 7; useRsD = 1;
        mduStartE = 1; mduDivE = 0;
        #1 check("co_stall", stall_vec(), STALL);
        tick();
        clr_inputs();
        check("co_busy_loaded", mdu_busy, 1'b1);
        for (int k = 2; k <= 6; k++) tick();
        check("co_busy_done", mdu_busy, 1'b0);

        // Reset one cycle at T+3 of a divide.
        mduStartE = 1; mduDivE = 1;
        tick();
        mduStartE = 0; mduDivE = 0; mduReadD = 1;
        tick();
        tick();
        check("rstmid_T+3_pre_busy", mdu_busy, 1'b1);
        rst_n = 1'b0;
        #1 check("rstmid_T+3_stall", stall_vec(), RSTV);
        check("rstmid_T+3_busy", mdu_busy, 1'b0);
        tick();
        rst_n = 1'b1;
        #1 check("rstmid_T+4_busy", mdu_busy, 1'b0);
        check("rstmid_T+4_stall", stall_vec(), RUN);
        tick();
        check("rstmid_T+5_busy", mdu_busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
